// File: rtl/seat_hold_mgr_if.sv
// Seat hold manager bus: request handshake, payment/cancel controls and
// the registered result/status outputs.
interface seat_hold_mgr_if #(
   parameter int NUM_SEATS = 32,
   parameter int SEAT_W    = 5
);
   logic                 req_valid;
   logic [SEAT_W-1:0]    req_seat;
   logic                 req_ready;
   logic                 pay_ok;
   logic                 cancel;
   logic                 grant;
   logic                 reject;
   logic                 booked;
   logic                 timeout;
   logic [SEAT_W-1:0]    hold_seat;
   logic                 busy;
   logic [NUM_SEATS-1:0] seat_map;
   logic [SEAT_W:0]      free_cnt;

   // Booking-flow side: issues requests and payment outcome.
   modport master (
      output req_valid, req_seat, pay_ok, cancel,
      input  req_ready, grant, reject, booked, timeout,
             hold_seat, busy, seat_map, free_cnt
   );

   // Seat manager side.
   modport slave (
      input  req_valid, req_seat, pay_ok, cancel,
      output req_ready, grant, reject, booked, timeout,
             hold_seat, busy, seat_map, free_cnt
   );
endinterface

// File: rtl/seat_hold_mgr.sv
// Seat inventory and hold manager. Checks one seat request at a time
// against the booked-seat map, holds a free seat while payment runs, and
// ends the hold on payment, cancel or hold-timer expiry.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; pay_ok/cancel ignored
// HOLD  | seat hold_seat reserved; waiting for cancel, pay_ok or expiry
module seat_hold_mgr #(
   parameter int NUM_SEATS   = 32,
   parameter int SEAT_W      = 5,
   parameter int HOLD_CYCLES = 16,
   parameter int TIMER_W     = 5
) (
   input  logic           clk,
   input  logic           rst,
   seat_hold_mgr_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [SEAT_W:0]    SEATS_N   = (SEAT_W+1)'(NUM_SEATS);
   localparam logic [TIMER_W-1:0] HOLD_INIT = TIMER_W'(HOLD_CYCLES - 1);

   logic [0:0]           state;
   logic [TIMER_W-1:0]   timer;
   logic [SEAT_W-1:0]    hold_seat_q;
   logic [NUM_SEATS-1:0] seat_map_q;
   logic [SEAT_W:0]      free_cnt_q;
   logic                 grant_q;
   logic                 reject_q;
   logic                 booked_q;
   logic                 timeout_q;

   logic                 req_out_of_range;
   logic                 req_bad;

   // Request qualification: out-of-range index is checked first so the
   // map lookup is never the deciding term for a nonexistent seat.
   always_comb begin
      req_out_of_range = ({1'b0, bus.req_seat} >= SEATS_N);
      req_bad          = req_out_of_range
                         || seat_map_q[bus.req_seat]
                         || (free_cnt_q == '0);
   end

   // Hold FSM, seat map, free counter, hold timer and result pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         timer       <= '0;
         hold_seat_q <= '0;
         seat_map_q  <= '0;
         free_cnt_q  <= SEATS_N;
         grant_q     <= 1'b0;
         reject_q    <= 1'b0;
         booked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         grant_q   <= 1'b0;
         reject_q  <= 1'b0;
         booked_q  <= 1'b0;
         timeout_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (req_bad) begin
                     reject_q <= 1'b1;
                  end else begin
                     grant_q     <= 1'b1;
                     hold_seat_q <= bus.req_seat;
                     timer       <= HOLD_INIT;
                     state       <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.cancel) begin
                  state <= ST_IDLE;
               end else if (bus.pay_ok) begin
                  seat_map_q[hold_seat_q] <= 1'b1;
                  free_cnt_q              <= free_cnt_q - 1'b1;
                  booked_q                <= 1'b1;
                  state                   <= ST_IDLE;
               end else if (timer == '0) begin
                  timeout_q <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs come straight from flops; busy/req_ready decode the 1-bit state.
   assign bus.req_ready = (state == ST_IDLE);
   assign bus.busy      = (state == ST_HOLD);
   assign bus.grant     = grant_q;
   assign bus.reject    = reject_q;
   assign bus.booked    = booked_q;
   assign bus.timeout   = timeout_q;
   assign bus.hold_seat = hold_seat_q;
   assign bus.seat_map  = seat_map_q;
   assign bus.free_cnt  = free_cnt_q;

endmodule

// File: tb/tb_seat_hold_mgr.sv
// Bench for seat_hold_mgr: scoreboard of expected result pulses plus a
// small reference model of the seat map, and a second narrow instance for
// out-of-range seat indices.
module tb_seat_hold_mgr;

   localparam int NUM_SEATS   = 32;
   localparam int SEAT_W      = 5;
   localparam int HOLD_CYCLES = 16;
   localparam int TIMER_W     = 5;

   localparam int S_SEATS = 20;
   localparam int S_HOLD  = 3;

   localparam int EV_GRANT   = 0;
   localparam int EV_REJECT  = 1;
   localparam int EV_BOOKED  = 2;
   localparam int EV_TIMEOUT = 3;

   typedef struct {
      int code;
      int seat;
   } sb_t;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   sb_t  sb_q[$];
   logic [NUM_SEATS-1:0] model_map;
   int   model_free;
   int   model_hold;
   bit   rand_mode;
   int   rand_booked;

   seat_hold_mgr_if #(.NUM_SEATS(NUM_SEATS), .SEAT_W(SEAT_W)) bus ();
   seat_hold_mgr_if #(.NUM_SEATS(S_SEATS),   .SEAT_W(SEAT_W)) bus2 ();

   seat_hold_mgr #(
      .NUM_SEATS(NUM_SEATS), .SEAT_W(SEAT_W),
      .HOLD_CYCLES(HOLD_CYCLES), .TIMER_W(TIMER_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   seat_hold_mgr #(
      .NUM_SEATS(S_SEATS), .SEAT_W(SEAT_W),
      .HOLD_CYCLES(S_HOLD), .TIMER_W(2)
   ) dut_small (
      .clk(clk),
      .rst(rst),
      .bus(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: exclusivity always; otherwise pop and compare scoreboard.
   always @(negedge clk) begin
      int n;
      int got;
      sb_t e;
      n = int'(bus.grant) + int'(bus.reject) + int'(bus.booked) + int'(bus.timeout);
      if (n > 1) begin
         checks++;
         errors++;
         $display("FAIL pulse_excl: %0d pulses high at %0t, required at most 1", n, $time);
      end else if (n == 1) begin
         got = bus.grant ? EV_GRANT : bus.reject ? EV_REJECT : bus.booked ? EV_BOOKED : EV_TIMEOUT;
         checks++;
         if (rand_mode) begin
            if (bus.booked) rand_booked++;
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: pulse code %0d at %0t, required none", got, $time);
         end else begin
            e = sb_q.pop_front();
            if (got != e.code) begin
               errors++;
               $display("FAIL sb_code: got pulse %0d, required %0d at %0t", got, e.code, $time);
            end else if (got == EV_GRANT && int'(bus.hold_seat) != e.seat) begin
               errors++;
               $display("FAIL sb_hold_seat: got %0d, required %0d", bus.hold_seat, e.seat);
            end
         end
      end
   end

   task automatic push_ev(input int code, input int seat);
      sb_t e;
      e.code = code;
      e.seat = seat;
      sb_q.push_back(e);
   endtask

   task automatic do_request(input int seat);
      int  waited;
      bit  exp_grant;
      waited = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) begin
         checks++;
         errors++;
         $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
         return;
      end
      exp_grant = (seat < NUM_SEATS) && (model_map[seat] == 1'b0) && (model_free > 0);
      push_ev(exp_grant ? EV_GRANT : EV_REJECT, seat);
      if (exp_grant) model_hold = seat;
      bus.req_valid = 1'b1;
      bus.req_seat  = SEAT_W'(seat);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic pay();
      @(negedge clk);
      bus.pay_ok = 1'b1;
      push_ev(EV_BOOKED, model_hold);
      model_map[model_hold] = 1'b1;
      model_free--;
      @(posedge clk);
      #1;
      bus.pay_ok = 1'b0;
   endtask

   task automatic abort_hold(input bit with_pay);
      @(negedge clk);
      bus.cancel = 1'b1;
      bus.pay_ok = with_pay;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      bus.pay_ok = 1'b0;
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      checks++;
      if (bus.seat_map !== model_map || int'(bus.free_cnt) != model_free) begin
         errors++;
         $display("FAIL %s: seat_map=%h free_cnt=%0d, required %h %0d",
                  tag, bus.seat_map, bus.free_cnt, model_map, model_free);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req_valid = 1'b0; bus.req_seat = '0; bus.pay_ok = 1'b0; bus.cancel = 1'b0;
      bus2.req_valid = 1'b0; bus2.req_seat = '0; bus2.pay_ok = 1'b0; bus2.cancel = 1'b0;
      model_map = '0;
      model_free = NUM_SEATS;
      model_hold = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.seat_map !== '0 ||
          bus.free_cnt !== 6'd32 || bus.hold_seat !== '0 ||
          {bus.grant, bus.reject, bus.booked, bus.timeout} !== 4'b0) begin
         errors++;
         $display("FAIL reset: ready=%b busy=%b map=%h free=%0d hold=%0d pulses=%b, required 1 0 0 32 0 0000",
                  bus.req_ready, bus.busy, bus.seat_map, bus.free_cnt, bus.hold_seat,
                  {bus.grant, bus.reject, bus.booked, bus.timeout});
      end
      checks++;
      if (bus2.free_cnt !== 6'd20) begin
         errors++;
         $display("FAIL reset_small_free: got %0d, required 20", bus2.free_cnt);
      end
      rst = 1'b1;
   endtask

   task automatic test_book();
      do_request(3);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.hold_seat !== 5'd3 || bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL book_hold: busy=%b hold_seat=%0d ready=%b, required 1 3 0",
                  bus.busy, bus.hold_seat, bus.req_ready);
      end
      @(negedge clk);
      pay();
      check_state("book_map");
      checks++;
      if (bus.seat_map !== 32'h0000_0008 || bus.free_cnt !== 6'd31) begin
         errors++;
         $display("FAIL book_abs: map=%h free=%0d, required 00000008 31", bus.seat_map, bus.free_cnt);
      end
   endtask

   task automatic test_reject();
      do_request(3);
      check_state("reject_taken_map");
   endtask

   task automatic test_range();
      int n;
      int bad[2] = '{20, 31};
      foreach (bad[i]) begin
         @(negedge clk);
         bus2.req_valid = 1'b1;
         bus2.req_seat  = SEAT_W'(bad[i]);
         @(posedge clk);
         #1;
         bus2.req_valid = 1'b0;
         checks++;
         if (bus2.reject !== 1'b1 || bus2.grant !== 1'b0 || bus2.busy !== 1'b0) begin
            errors++;
            $display("FAIL range_reject seat %0d: reject=%b grant=%b busy=%b, required 1 0 0",
                     bad[i], bus2.reject, bus2.grant, bus2.busy);
         end
      end
      @(negedge clk);
      bus2.req_valid = 1'b1;
      bus2.req_seat  = 5'd19;
      @(posedge clk);
      #1;
      bus2.req_valid = 1'b0;
      checks++;
      if (bus2.grant !== 1'b1 || bus2.hold_seat !== 5'd19) begin
         errors++;
         $display("FAIL range_top_grant: grant=%b hold=%0d, required 1 19", bus2.grant, bus2.hold_seat);
      end
      n = 0;
      while (bus2.timeout !== 1'b1 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != S_HOLD) begin
         errors++;
         $display("FAIL range_timeout_lat: %0d cycles, required %0d", n, S_HOLD);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_request(5);
      push_ev(EV_TIMEOUT, 5);
      n = 0;
      while (bus.timeout !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != HOLD_CYCLES) begin
         errors++;
         $display("FAIL timeout_lat: %0d cycles grant->timeout, required %0d", n, HOLD_CYCLES);
      end
      check_state("timeout_map");
      do_request(5);
      abort_hold(1'b0);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL cancel_idle: busy=%b ready=%b, required 0 1", bus.busy, bus.req_ready);
      end
   endtask

   task automatic test_priority();
      do_request(7);
      abort_hold(1'b1);
      check_state("prio_cancel_map");
      @(negedge clk);
      bus.pay_ok = 1'b1;
      @(negedge clk);
      bus.pay_ok = 1'b0;
      check_state("idle_pay_ignored");
      do_request(7);
      repeat (HOLD_CYCLES - 1) @(posedge clk);
      #1;
      bus.pay_ok = 1'b1;
      push_ev(EV_BOOKED, 7);
      model_map[7] = 1'b1;
      model_free--;
      @(posedge clk);
      #1;
      bus.pay_ok = 1'b0;
      checks++;
      if (bus.booked !== 1'b1 || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL last_cycle_pay: booked=%b timeout=%b, required 1 0", bus.booked, bus.timeout);
      end
      check_state("last_cycle_map");
   endtask

   task automatic test_full();
      int probe[3] = '{0, 10, 31};
      for (int s = 0; s < NUM_SEATS; s++) begin
         if (model_map[s] == 1'b0) begin
            do_request(s);
            pay();
         end
      end
      check_state("full_map");
      checks++;
      if (bus.free_cnt !== 6'd0 || bus.seat_map !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL full_abs: free=%0d map=%h, required 0 ffffffff", bus.free_cnt, bus.seat_map);
      end
      foreach (probe[i]) begin
         do_request(probe[i]);
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL full_ready seat %0d: ready=%b busy=%b, required 1 0",
                     probe[i], bus.req_ready, bus.busy);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      do_request(9);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_map = '0;
      model_free = NUM_SEATS;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.seat_map !== '0 ||
          bus.free_cnt !== 6'd32 || {bus.grant, bus.reject, bus.booked, bus.timeout} !== 4'b0) begin
         errors++;
         $display("FAIL mid_hold_reset: busy=%b ready=%b map=%h free=%0d pulses=%b, required 0 1 0 32 0000",
                  bus.busy, bus.req_ready, bus.seat_map, bus.free_cnt,
                  {bus.grant, bus.reject, bus.booked, bus.timeout});
      end
      repeat (HOLD_CYCLES + 2) @(negedge clk);
      checks++;
      if (bus.seat_map !== '0 || bus.free_cnt !== 6'd32) begin
         errors++;
         $display("FAIL mid_hold_no_late_book: map=%h free=%0d, required 0 32", bus.seat_map, bus.free_cnt);
      end
   endtask

   task automatic test_random();
      rand_booked = 0;
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         bus.req_valid = ($urandom_range(0, 1) == 1);
         bus.req_seat  = SEAT_W'($urandom_range(0, 7));
         bus.pay_ok    = ($urandom_range(0, 5) == 0);
         bus.cancel    = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.pay_ok    = 1'b0;
      bus.cancel    = 1'b1;
      repeat (3) @(negedge clk);
      bus.cancel = 1'b0;
      repeat (2) @(negedge clk);
      rand_mode = 1'b0;
      checks++;
      if (int'(bus.free_cnt) != NUM_SEATS - rand_booked) begin
         errors++;
         $display("FAIL random_free: free_cnt=%0d, required %0d", bus.free_cnt, NUM_SEATS - rand_booked);
      end
   endtask

   initial begin
      int waited;
      rand_mode = 1'b0;
      rand_booked = 0;
      test_reset();
      test_book();
      test_reject();
      test_range();
      test_timeout();
      test_priority();
      test_full();
      test_reset_mid_hold();
      test_random();
      waited = 0;
      while (sb_q.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected pulses never seen, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
